// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the 16-point radix-2 FFT stage controller.
// Contents:
//   fft_state_t   - controller phase encoding (LOAD / COMPUTE / UNLOAD)
//   DEF_*         - default geometry of the FFT datapath
//   bitrev()      - reverses the bits of a buffer address
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } fft_state_t;

    localparam int DEF_N_POINTS = 16;
    localparam int DEF_N_STAGES = 4;
    localparam int DEF_AW       = 4;

    function automatic logic [DEF_AW-1:0] bitrev(input logic [DEF_AW-1:0] addr);
        logic [DEF_AW-1:0] rev;
        for (int i = 0; i < DEF_AW; i++) begin
            rev[i] = addr[DEF_AW-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_out_skid.sv
// Two-entry FIFO between the buffer read port and the output stream.
// Each entry carries {last, data}. A push is accepted when there is room
// (including room freed by a pop in the same cycle); a pop only takes
// effect while the FIFO holds data.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data this cycle
//   push_data   - {last, data} entry
//   pop         - consumer takes the head entry
//   out_valid   - FIFO not empty
//   out_data    - head entry, stable until popped
//   count       - current occupancy (0..2)
module fft_out_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         pop_s;
    logic         push_s;

    assign pop_s     = pop & (count_r != 2'd0);
    assign push_s    = push & ((count_r != 2'd2) | pop_s);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage, pointer and occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fft_stage_controller.sv
// Sequencer for the 16-point radix-2 FFT datapath.
// A frame runs LOAD (stream N_POINTS samples into the buffer), COMPUTE
// (N_STAGES butterfly passes of BF_LAT cycles, each ending in a write-back)
// and UNLOAD (read the buffer through a 2-entry skid FIFO to a
// backpressured output stream), then returns to LOAD.
// Configuration macro: FFT_BITREV_OUT_EN - when defined, the buffer is read
// in bit-reversed address order so results leave in natural frequency
// order; timing and handshakes are unchanged.
// Ports:
//   clk, rst_n                         - clock, asynchronous active-low reset
//   s_valid/s_ready/s_data             - input sample stream
//   m_valid/m_ready/m_data/m_last      - output sample stream
//   write_enable/write_address/data_in - buffer host-write port
//   stage, write_back                  - butterfly pass select and capture strobe
//   read_enable/read_address/data_out  - buffer read port (1-cycle latency)
//   busy                               - high during COMPUTE and UNLOAD
//   frame_done                         - pulse after the final output handshake
module fft_stage_controller
    import fft_ctrl_pkg::*;
#(
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int N_STAGES = DEF_N_STAGES,
    parameter int BF_LAT   = 2,
    parameter int DW       = 32,
    parameter int AW       = DEF_AW,
    localparam int STG_W   = $clog2(N_STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic             m_last,
    output logic             write_enable,
    output logic [AW-1:0]    write_address,
    output logic [DW-1:0]    data_in,
    output logic [STG_W-1:0] stage,
    output logic             write_back,
    output logic             read_enable,
    output logic [AW-1:0]    read_address,
    input  logic [DW-1:0]    data_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int WCW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [AW-1:0]    LD_LAST   = AW'(N_POINTS - 1);
    localparam logic [AW:0]      RD_END    = (AW+1)'(N_POINTS);
    localparam logic [AW:0]      RD_LAST   = (AW+1)'(N_POINTS - 1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(N_STAGES - 1);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'(BF_LAT - 1);

    fft_state_t       state_r;
    fft_state_t       state_next_s;
    logic [AW-1:0]    ld_cnt_r;
    logic [AW:0]      rd_cnt_r;
    logic [STG_W-1:0] stage_r;
    logic [WCW-1:0]   wait_cnt_r;
    logic             inflight_r;
    logic             inflight_last_r;
    logic             frame_done_r;

    logic             load_beat_s;
    logic             wb_s;
    logic             rd_issue_s;
    logic             pop_s;
    logic [2:0]       occupancy_s;
    logic [AW-1:0]    rd_addr_s;
    logic             fifo_valid_s;
    logic [DW:0]      fifo_head_s;
    logic [1:0]       fifo_count_s;

`ifdef FFT_BITREV_OUT_EN
    assign rd_addr_s = bitrev(rd_cnt_r[AW-1:0]);
`else
    assign rd_addr_s = rd_cnt_r[AW-1:0];
`endif

    // Handshake qualifiers and the read-issue rule. Occupancy counts the
    // entries that will remain after this cycle's pop plus the read already
    // in flight, which keeps at most two samples outstanding while still
    // allowing one read per cycle when the consumer keeps up.
    always_comb begin
        load_beat_s = (state_r == ST_LOAD) && s_valid;
        wb_s        = (state_r == ST_COMPUTE) && (wait_cnt_r == WAIT_LAST);
        pop_s       = fifo_valid_s && m_ready;
        occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_issue_s  = (state_r == ST_UNLOAD) && (rd_cnt_r < RD_END) && (occupancy_s < 3'd2);
    end

    // Next-state logic for the LOAD -> COMPUTE -> UNLOAD frame sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_beat_s && (ld_cnt_r == LD_LAST)) begin
                    state_next_s = ST_COMPUTE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (wb_s && (stage_r == STG_LAST)) begin
                    state_next_s = ST_UNLOAD;
                end else begin
                    state_next_s = ST_COMPUTE;
                end
            end
            ST_UNLOAD: begin
                if (pop_s && fifo_head_s[DW]) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_UNLOAD;
                end
            end
            default: state_next_s = ST_LOAD;
        endcase
    end

    // Output decode; the host-write port is a zero-latency pass-through.
    always_comb begin
        s_ready       = (state_r == ST_LOAD);
        busy          = (state_r != ST_LOAD);
        write_enable  = load_beat_s;
        write_address = ld_cnt_r;
        if (load_beat_s) begin
            data_in = s_data;
        end else begin
            data_in = {DW{1'b0}};
        end
        stage        = stage_r;
        write_back   = wb_s;
        read_enable  = rd_issue_s;
        read_address = rd_addr_s;
        m_valid      = fifo_valid_s;
        m_data       = fifo_head_s[DW-1:0];
        m_last       = fifo_valid_s && fifo_head_s[DW];
        frame_done   = frame_done_r;
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Load beat counter; wraps to 0 on the final beat of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_r <= {AW{1'b0}};
        end else if (load_beat_s) begin
            if (ld_cnt_r == LD_LAST) begin
                ld_cnt_r <= {AW{1'b0}};
            end else begin
                ld_cnt_r <= ld_cnt_r + AW'(1);
            end
        end
    end

    // Butterfly pass and latency counters; both rest at 0 outside COMPUTE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r    <= {STG_W{1'b0}};
            wait_cnt_r <= {WCW{1'b0}};
        end else if (state_r == ST_COMPUTE) begin
            if (wb_s) begin
                wait_cnt_r <= {WCW{1'b0}};
                if (stage_r == STG_LAST) begin
                    stage_r <= {STG_W{1'b0}};
                end else begin
                    stage_r <= stage_r + STG_W'(1);
                end
            end else begin
                wait_cnt_r <= wait_cnt_r + WCW'(1);
            end
        end else begin
            stage_r    <= {STG_W{1'b0}};
            wait_cnt_r <= {WCW{1'b0}};
        end
    end

    // Read counter, in-flight tracking and the frame completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r        <= {(AW+1){1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            frame_done_r    <= 1'b0;
        end else begin
            if (rd_issue_s) begin
                rd_cnt_r <= rd_cnt_r + (AW+1)'(1);
            end else if (state_r != ST_UNLOAD) begin
                rd_cnt_r <= {(AW+1){1'b0}};
            end
            inflight_r      <= rd_issue_s;
            inflight_last_r <= rd_issue_s && (rd_cnt_r == RD_LAST);
            frame_done_r    <= pop_s && fifo_head_s[DW];
        end
    end

    fft_out_skid #(
        .W (DW + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data ({inflight_last_r, data_out}),
        .pop       (pop_s),
        .out_valid (fifo_valid_s),
        .out_data  (fifo_head_s),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_fft_stage_controller.sv
module tb_fft_stage_controller;

    localparam int N     = 16;
    localparam int NS    = 4;
    localparam int BF    = 2;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int STG_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             s_valid = 1'b0;
    logic             m_ready = 1'b0;
    logic [DW-1:0]    s_data = 32'd0;
    logic [DW-1:0]    data_out = 32'd0;
    logic             s_ready, m_valid, m_last, write_enable, write_back;
    logic             read_enable, busy, frame_done;
    logic [DW-1:0]    m_data, data_in;
    logic [AW-1:0]    write_address, read_address;
    logic [STG_W-1:0] stage;

    fft_stage_controller dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .write_enable(write_enable), .write_address(write_address), .data_in(data_in),
        .stage(stage), .write_back(write_back),
        .read_enable(read_enable), .read_address(read_address), .data_out(data_out),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [27:0] salt = 28'd0;

    int exp_wb[4] = '{1, 3, 5, 7};
`ifdef FFT_BITREV_OUT_EN
    int exp_ra[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
    int exp_ra[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
    int pat[4] = '{1, 0, 0, 1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Output order of the buffer addresses, from the address rule alone.
    function automatic int exp_addr(input int k);
        int r;
        r = k;
`ifdef FFT_BITREV_OUT_EN
        r = 0;
        for (int i = 0; i < AW; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (AW - 1 - i));
        end
`endif
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed { logic last; logic [DW-1:0] data; } ent_t;
    int   mph = 0;     // 0 load, 1 compute, 2 unload
    int   mld = 0;     // beats loaded
    int   mcyc = 0;    // compute cycle index
    int   mrd = 0;     // reads issued
    bit   mfd = 1'b0;  // frame_done expected this cycle
    bit   infl = 1'b0;
    ent_t infl_e;
    ent_t fq[$];

    function automatic bit exp_re();
        int pop;
        int inf;
        pop = (fq.size() > 0 && m_ready) ? 1 : 0;
        inf = infl ? 1 : 0;
        return (mph == 2) && (mrd < N) && ((fq.size() - pop + inf) < 2);
    endfunction

    initial forever begin
        bit   re_e, pop_e, done;
        ent_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mph = 0; mld = 0; mcyc = 0; mrd = 0; mfd = 1'b0; infl = 1'b0;
            fq.delete();
        end else begin
            re_e  = exp_re();
            pop_e = (fq.size() > 0) && m_ready;
            done  = 1'b0;
            mfd   = 1'b0;
            if (mph == 0) begin
                if (s_valid) begin
                    if (mld == N - 1) begin mph = 1; mcyc = 0; mld = 0; end
                    else mld++;
                end
            end else if (mph == 1) begin
                if (mcyc == NS * BF - 1) mph = 2;
                else mcyc++;
            end else begin
                if (pop_e) begin e = fq.pop_front(); done = e.last; end
                if (infl) fq.push_back(infl_e);
                infl = re_e;
                if (re_e) begin
                    infl_e.last = (mrd == N - 1);
                    infl_e.data = {salt, AW'(exp_addr(mrd))};
                    mrd++;
                end
                if (done) begin mph = 0; mrd = 0; mfd = 1'b1; end
            end
        end
    end

    // ---------------- compare process ----------------
    bit          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = 32'd0;
    initial forever begin
        bit re_e;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_s_ready", s_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_write_back", write_back, 0);
            chk("rst_read_enable", read_enable, 0);
            chk("rst_stage", stage, 0);
            chk("rst_frame_done", frame_done, 0);
            prev_stall = 1'b0;
        end else begin
            re_e = exp_re();
            chk("s_ready", s_ready, mph == 0);
            chk("busy", busy, mph != 0);
            chk("write_enable", write_enable, (mph == 0) && s_valid);
            if (mph == 0 && s_valid) begin
                chk("write_address", write_address, mld);
                chk("data_in", data_in, s_data);
            end
            chk("stage", stage, (mph == 1) ? (mcyc / BF) : 0);
            chk("write_back", write_back, (mph == 1) && ((mcyc % BF) == BF - 1));
            chk("read_enable", read_enable, re_e);
            if (re_e) chk("read_address", read_address, exp_addr(mrd));
            chk("m_valid", m_valid, fq.size() > 0);
            if (fq.size() > 0) begin
                chk("m_data", m_data, fq[0].data);
                chk("m_last", m_last, fq[0].last);
            end
            chk("frame_done", frame_done, mfd);
            chk("strobe_exclusive", (32'(write_enable) + 32'(write_back) + 32'(read_enable)) <= 1, 1);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // ---------------- event recorder for literal checks ----------------
    int busy_start, first_re, hs_cnt, last_cnt, hs_first, hs_lastcyc;
    int nbeat, outst, max_outst, sr_drop;
    int fd_cnt = 0;
    int wb_q[$], wbs_q[$], ra_q[$], wa_q[$], wcyc_q[$];
    bit busy_prev = 1'b0, sready_prev = 1'b0, cap_re = 1'b0;
    logic [AW-1:0] cap_addr = 4'd0;

    initial forever begin
        @(negedge clk);
        cap_re   = read_enable && rst_n;
        cap_addr = read_address;
        if (rst_n) begin
            if (busy && !busy_prev) busy_start = cyc;
            if (!s_ready && sready_prev) sr_drop = cyc;
            if (write_enable) begin
                wa_q.push_back(int'(write_address)); wcyc_q.push_back(cyc); nbeat++;
            end
            if (write_back) begin
                wb_q.push_back(cyc - busy_start); wbs_q.push_back(int'(stage));
            end
            if (read_enable) begin
                if (ra_q.size() == 0) first_re = cyc;
                ra_q.push_back(int'(read_address)); outst++;
            end
            if (m_valid && m_ready) begin
                if (hs_cnt == 0) hs_first = cyc;
                hs_lastcyc = cyc; hs_cnt++; outst--;
                if (m_last) last_cnt++;
            end
            if (outst > max_outst) max_outst = outst;
            if (frame_done) fd_cnt++;
        end
        busy_prev   = busy;
        sready_prev = s_ready;
    end

    task automatic clear_rec();
        hs_cnt = 0; last_cnt = 0; nbeat = 0; outst = 0; max_outst = 0;
        first_re = -1; sr_drop = -1;
        wb_q.delete(); wbs_q.delete(); ra_q.delete(); wa_q.delete(); wcyc_q.delete();
    endtask

    // One clock: the emulated buffer answers last cycle's read, then inputs may change.
    task automatic step();
        @(posedge clk);
        #2;
        if (cap_re) data_out = {salt, cap_addr};
        else data_out = $urandom;
        cyc++;
    endtask

    task automatic drive(input int mode, input int pc);
        if (mode == 0) begin
            s_valid = 1'b1; s_data = 32'(nbeat); m_ready = 1'b1;
        end else if (mode == 1) begin
            s_valid = ($urandom % 4) != 0; s_data = $urandom; m_ready = pat[pc % 4] != 0;
        end else begin
            s_valid = ($urandom % 4) != 0; s_data = $urandom; m_ready = ($urandom % 3) != 0;
        end
    endtask

    task automatic run_frame(input int mode);
        int start_fd;
        int n;
        start_fd = fd_cnt;
        n = 0;
        salt = 28'($urandom);
        clear_rec();
        while (fd_cnt == start_fd && n < 400) begin
            drive(mode, n);
            step();
            n++;
        end
        chk("frame_completes", fd_cnt - start_fd, 1);
    endtask

    task automatic chk_reset_outs();
        chk("ro_s_ready", s_ready, 1);
        chk("ro_busy", busy, 0);
        chk("ro_m_valid", m_valid, 0);
        chk("ro_m_last", m_last, 0);
        chk("ro_m_data", m_data, 0);
        chk("ro_write_enable", write_enable, 0);
        chk("ro_write_address", write_address, 0);
        chk("ro_data_in", data_in, 0);
        chk("ro_stage", stage, 0);
        chk("ro_write_back", write_back, 0);
        chk("ro_read_enable", read_enable, 0);
        chk("ro_read_address", read_address, 0);
        chk("ro_frame_done", frame_done, 0);
    endtask

    initial begin
        bit ok;
        int n;
        #1 rst_n = 1'b0;
        step(); step();
        chk_reset_outs();
        #1 rst_n = 1'b1;

        // Frame 0: s_valid held, s_data = k, m_ready high throughout.
        run_frame(0);
        ok = (wa_q.size() >= 16);
        for (int i = 0; i < 16 && ok; i++) begin
            if (wa_q[i] != i || wcyc_q[i] != wcyc_q[0] + i) ok = 1'b0;
        end
        chk("wr_addr_steps", ok, 1);
        chk("s_ready_drop", sr_drop, (wcyc_q.size() >= 16) ? wcyc_q[15] + 1 : -2);
        chk("busy_start", busy_start, sr_drop);
        chk("wb_count", wb_q.size(), 4);
        for (int i = 0; i < 4 && i < wb_q.size(); i++) begin
            chk("wb_cycle", wb_q[i], exp_wb[i]);
            chk("wb_stage", wbs_q[i], i);
        end
        chk("unload_entry", first_re - busy_start, NS * BF);
        chk("hs_count", hs_cnt, 16);
        chk("back_to_back", hs_lastcyc - hs_first, 15);
        chk("last_count", last_cnt, 1);
        chk("ra_count", ra_q.size(), 16);
        for (int i = 0; i < 16 && i < ra_q.size(); i++) chk("ra_seq", ra_q[i], exp_ra[i]);

        // Frame 1: m_ready pattern 1,0,0,1.
        run_frame(1);
        chk("bp_hs_count", hs_cnt, 16);
        chk("bp_last_count", last_cnt, 1);
        chk("bp_outstanding", max_outst <= 2, 1);
        for (int i = 0; i < 16 && i < ra_q.size(); i++) chk("bp_ra_seq", ra_q[i], exp_ra[i]);

        // Reset during COMPUTE stage 2.
        clear_rec();
        n = 0;
        while (!(busy && stage == 2'd2) && n < 100) begin
            drive(0, n);
            step();
            n++;
        end
        chk("reach_stage2", (busy && stage == 2'd2), 1);
        s_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outs();
        step();
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_stage", stage, 0);
        chk("post_rst_busy", busy, 0);

        // Randomized frames.
        for (int f = 0; f < 4; f++) begin
            run_frame(2);
            chk("rnd_hs_count", hs_cnt, 16);
            chk("rnd_outstanding", max_outst <= 2, 1);
        end
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
